// File: rtl/mem_txn_controller_if.sv
// Signal bundle for mem_txn_controller: request/response handshake plus serial PHY streams.
// master: the controller; slave: the requester and serial PHY side.
interface mem_txn_controller_if #(
  parameter int unsigned IO_BITS        = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8
);
  localparam int unsigned WORD_BITS = IO_BITS * PAYLOAD_CYCLES;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [WORD_BITS-1:0] req_addr;
  logic [WORD_BITS-1:0] req_wdata;

  logic                 resp_valid;
  logic [WORD_BITS-1:0] resp_rdata;
  logic                 resp_error;

  logic                 tx_command_valid;
  logic [1:0]           tx_command;
  logic                 tx_command_started;
  logic [IO_BITS-1:0]   tx_data;
  logic                 tx_data_next;
  logic                 tx_done;

  logic                 rx_data_valid;
  logic                 rx_done;
  logic [IO_BITS-1:0]   rx_pins;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    output tx_command_valid, tx_command, tx_data,
    input  tx_command_started, tx_data_next, tx_done,
    input  rx_data_valid, rx_done, rx_pins
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    input  tx_command_valid, tx_command, tx_data,
    output tx_command_started, tx_data_next, tx_done,
    output rx_data_valid, rx_done, rx_pins
  );
endinterface

// File: rtl/mem_txn_controller.sv
// Serial memory transaction controller: streams address/write data LSB-first to a serial PHY and
// collects read responses. Define MEM_TXN_TIMEOUT_EN to enable the read-response timeout.
module mem_txn_controller #(
  parameter int unsigned IO_BITS        = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_txn_controller_if.master bus
);
  localparam int unsigned WORD_BITS = IO_BITS * PAYLOAD_CYCLES;

  localparam logic [1:0] CmdRead  = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd1;
  localparam logic [1:0] CmdWdata = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StSendAddr,
    StSendWdata,
    StWaitResp
  } state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  // Holds the latched address while it is being sent, then the write data.
  logic [WORD_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_BITS-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]           cmd_q, cmd_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [WORD_BITS-1:0] rx_word;

`ifdef MEM_TXN_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'd254;
  logic [7:0] timeout_cnt_q, timeout_cnt_d;
  logic       resp_error_q, resp_error_d;
`endif

  assign rx_word = {bus.rx_pins, rx_shift_q[WORD_BITS-1:IO_BITS]};

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    resp_rdata_d = resp_rdata_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = cmd_valid_q;
    resp_valid_d = 1'b0;
`ifdef MEM_TXN_TIMEOUT_EN
    timeout_cnt_d = '0;
    resp_error_d  = 1'b0;
`endif

    if (bus.tx_command_started) begin
      cmd_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d     = bus.req_write;
          wdata_d     = bus.req_wdata;
          tx_shift_d  = bus.req_addr;
          rx_shift_d  = '0;
          cmd_d       = bus.req_write ? CmdWrite : CmdRead;
          cmd_valid_d = 1'b1;
          state_d     = StSendAddr;
        end
      end

      StSendAddr: begin
        if (bus.tx_data_next) begin
          tx_shift_d = tx_shift_q >> IO_BITS;
        end
        if (bus.tx_done) begin
          if (write_q) begin
            tx_shift_d  = wdata_q;
            cmd_d       = CmdWdata;
            cmd_valid_d = 1'b1;
            state_d     = StSendWdata;
          end else begin
            state_d = StWaitResp;
          end
        end
      end

      StSendWdata: begin
        if (bus.tx_data_next) begin
          tx_shift_d = tx_shift_q >> IO_BITS;
        end
        if (bus.tx_done) begin
          state_d = StIdle;
        end
      end

      StWaitResp: begin
        if (bus.rx_data_valid) begin
          rx_shift_d = rx_word;
          if (bus.rx_done) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = rx_word;
            state_d      = StIdle;
          end
        end
`ifdef MEM_TXN_TIMEOUT_EN
        // Fires on the 255th consecutive cycle without rx activity.
        else if (timeout_cnt_q == TimeoutLast) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          resp_rdata_d = '0;
          state_d      = StIdle;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      resp_rdata_q <= '0;
      cmd_q        <= CmdRead;
      cmd_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      resp_rdata_q <= resp_rdata_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      resp_valid_q <= resp_valid_d;
    end
  end

`ifdef MEM_TXN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt_q <= '0;
      resp_error_q  <= 1'b0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
      resp_error_q  <= resp_error_d;
    end
  end

  assign bus.resp_error = resp_error_q;
`else
  assign bus.resp_error = 1'b0;
`endif

  assign bus.req_ready        = (state_q == StIdle);
  assign bus.tx_command_valid = cmd_valid_q;
  assign bus.tx_command       = cmd_q;
  assign bus.tx_data          = tx_shift_q[IO_BITS-1:0];
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_rdata       = resp_rdata_q;
endmodule

// File: tb/tb_mem_txn_controller.sv
// Scoreboard bench for mem_txn_controller: a serial PHY/memory model answers commands, monitors
// compare tx streams and responses against expectations queued by the directed stimulus.
module tb_mem_txn_controller;
  localparam int RespDelay = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // {cmd, word} per tx message; {error, rdata} per response
  logic [17:0] exp_tx[$];
  logic [16:0] exp_resp[$];
  logic [15:0] mem[logic [15:0]];

  logic        rx_silent = 1'b0;
  logic [15:0] inject_word = 16'h5A5A;
  int          inject_req = 0;
  int          inject_ack = 0;

  always #5 clk = ~clk;

  mem_txn_controller_if #(.IO_BITS(2), .PAYLOAD_CYCLES(8)) bus ();

  mem_txn_controller #(.IO_BITS(2), .PAYLOAD_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Serial PHY and memory model
  typedef enum int {PhIdle, PhPay, PhDone, PhDelay, PhRx} phase_e;
  initial begin : phy
    phase_e      ph;
    int          cnt;
    logic [1:0]  cmd_cap;
    logic [15:0] word;
    logic [15:0] rword;
    logic [17:0] e;
    ph = PhIdle;
    cnt = 0;
    cmd_cap = 2'd0;
    word = 16'h0;
    rword = 16'h0;
    bus.tx_command_started = 1'b0;
    bus.tx_data_next = 1'b0;
    bus.tx_done = 1'b0;
    bus.rx_data_valid = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_pins = 2'd0;
    forever begin
      @(negedge clk);
      bus.tx_command_started = 1'b0;
      bus.tx_data_next = 1'b0;
      bus.tx_done = 1'b0;
      bus.rx_data_valid = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_pins = 2'd0;
      if (!rst_n) begin
        ph = PhIdle;
      end else begin
        case (ph)
          PhIdle: begin
            if (bus.tx_command_valid) begin
              cmd_cap = bus.tx_command;
              bus.tx_command_started = 1'b1;
              cnt = 0;
              word = 16'h0;
              ph = PhPay;
            end else if (inject_req != inject_ack) begin
              rword = inject_word;
              cnt = 0;
              inject_ack++;
              ph = PhRx;
            end
          end
          PhPay: begin
            bus.tx_data_next = 1'b1;
            word[2*cnt +: 2] = bus.tx_data;
            cnt++;
            if (cnt == 8) ph = PhDone;
          end
          PhDone: begin
            bus.tx_done = 1'b1;
            check("tx_command_stable", 32'(bus.tx_command), 32'(cmd_cap));
            if (exp_tx.size() == 0) begin
              fail($sformatf("unexpected_tx: got cmd %0d word %h, required none", cmd_cap, word));
            end else begin
              e = exp_tx.pop_front();
              check("tx_cmd", 32'(cmd_cap), 32'(e[17:16]));
              check("tx_payload", 32'(word), 32'(e[15:0]));
            end
            if (cmd_cap == 2'd0 && !rx_silent) begin
              rword = mem.exists(word) ? mem[word] : 16'h0;
              cnt = 0;
              ph = PhDelay;
            end else begin
              ph = PhIdle;
            end
          end
          PhDelay: begin
            cnt++;
            if (cnt == RespDelay) begin
              cnt = 0;
              ph = PhRx;
            end
          end
          PhRx: begin
            bus.rx_data_valid = 1'b1;
            bus.rx_pins = rword[2*cnt +: 2];
            bus.rx_done = (cnt == 7);
            cnt++;
            if (cnt == 8) ph = PhIdle;
          end
          default: ph = PhIdle;
        endcase
      end
    end
  end

  // Response monitor
  initial begin : resp_monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (exp_resp.size() == 0) begin
          fail($sformatf("unexpected_resp: got rdata %h error %0d, required no response",
                         bus.resp_rdata, bus.resp_error));
        end else begin
          e = exp_resp.pop_front();
          check("resp_rdata", 32'(bus.resp_rdata), 32'(e[15:0]));
          check("resp_error", 32'(bus.resp_error), 32'(e[16]));
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    int t;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    t = 0;
    while (!bus.req_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail("req_accept: request not accepted within 3000 cycles");
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic read_txn(input logic [15:0] addr, input logic [15:0] rdata);
    exp_tx.push_back({2'd0, addr});
    exp_resp.push_back({1'b0, rdata});
    issue(1'b0, addr, 16'h0);
  endtask

  task automatic write_txn(input logic [15:0] addr, input logic [15:0] wdata);
    exp_tx.push_back({2'd1, addr});
    exp_tx.push_back({2'd2, wdata});
    issue(1'b1, addr, wdata);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || exp_resp.size() != 0 || !bus.req_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail("wait_idle: outstanding transaction did not complete in 3000 cycles");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_command_valid"}, 32'(bus.tx_command_valid), 32'd0);
    check({pfx, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({pfx, "_resp_error"}, 32'(bus.resp_error), 32'd0);
    check({pfx, "_tx_command"}, 32'(bus.tx_command), 32'd0);
    check({pfx, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({pfx, "_resp_rdata"}, 32'(bus.resp_rdata), 32'd0);
  endtask

  task automatic pulse_reset(input string pfx);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs(pfx);
    exp_tx.delete();
    exp_resp.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin : main
    int lat;
    int t;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 16'h0;
    mem[16'h1234] = 16'hBEEF;
    mem[16'h0001] = 16'h1111;
    mem[16'h0002] = 16'h2222;
    mem[16'h0040] = 16'h0F0F;
    mem[16'h0077] = 16'hC3C3;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("por_req_ready", 32'(bus.req_ready), 32'd1);

    // Read 0x1234 -> 0xBEEF; accept-to-response latency with a 2-cycle responder
    read_txn(16'h1234, 16'hBEEF);
    lat = 1;
    while (!bus.resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("read_latency", 32'(lat), 32'd21);
    wait_idle();

    // Write: cmd 1 + address stream, cmd 2 + data stream, no response
    write_txn(16'h00FF, 16'hA5A5);
    wait_idle();
    check("write_req_ready", 32'(bus.req_ready), 32'd1);
    check("write_rdata_hold", 32'(bus.resp_rdata), 32'h0000BEEF);

    // Back-to-back reads with req_valid held high
    exp_tx.push_back({2'd0, 16'h0001});
    exp_resp.push_back({1'b0, 16'h1111});
    exp_tx.push_back({2'd0, 16'h0002});
    exp_resp.push_back({1'b0, 16'h2222});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0001;
    @(negedge clk);
    bus.req_addr = 16'h0002;
    t = 0;
    while (!bus.req_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("b2b_ready_low_cycles", 32'(t), 32'd20);
    check("b2b_accept_with_resp", 32'(bus.resp_valid), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_idle();

    // rx stream while idle must be ignored
    inject_req++;
    t = 0;
    while (inject_ack != inject_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail("inject: PHY model did not start injection");
    repeat (12) @(negedge clk);
    check("idle_rx_rdata_hold", 32'(bus.resp_rdata), 32'h00002222);
    read_txn(16'h0040, 16'h0F0F);
    wait_idle();
    check("post_inject_rdata_hold", 32'(bus.resp_rdata), 32'h00000F0F);

    // Reset during SEND_ADDR
    read_txn(16'h0077, 16'hC3C3);
    repeat (4) @(negedge clk);
    pulse_reset("rst_send_addr");
    read_txn(16'h0077, 16'hC3C3);
    wait_idle();

    // Reset during WAIT_RESP, partway through the rx stream
    read_txn(16'h1234, 16'hBEEF);
    repeat (13) @(negedge clk);
    pulse_reset("rst_wait_resp");
    repeat (20) @(negedge clk);
    read_txn(16'h0001, 16'h1111);
    wait_idle();

`ifdef MEM_TXN_TIMEOUT_EN
    // Silent responder: error response after 255 WAIT_RESP cycles
    rx_silent = 1'b1;
    exp_tx.push_back({2'd0, 16'h0002});
    exp_resp.push_back({1'b1, 16'h0000});
    issue(1'b0, 16'h0002, 16'h0);
    lat = 1;
    while (!bus.resp_valid && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency", 32'(lat), 32'd266);
    rx_silent = 1'b0;
    wait_idle();
    read_txn(16'h0002, 16'h2222);
    wait_idle();
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
